// File: rtl/input_skew_queue.sv
// input_skew_queue: buffers up to DEPTH vectors of N lanes and streams them
// diagonally skewed (lane i delayed i cycles) onto one systolic mesh edge.
// Ports:
//   clk_i, rstn_i     clock, asynchronous active-low reset
//   load_valid_i/load_ready_o/load_data_i   one vector per accepted beat
//   start_i           begin streaming the buffered vectors
//   data_o            skewed lane outputs (mesh north_i or west_i)
//   valid_o           lane 0 carries a real element (mesh inputs_valid_i)
//   last_element_o    final element on lane N-1 (mesh last_element_i)
//   busy_o, count_o   streaming in progress, vectors buffered
module input_skew_queue #(
    parameter int N          = 2,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                             clk_i,
    input  logic                             rstn_i,
    input  logic                             load_valid_i,
    output logic                             load_ready_o,
    input  logic [0:N-1][DATA_WIDTH-1:0]     load_data_i,
    input  logic                             start_i,
    output logic [0:N-1][DATA_WIDTH-1:0]     data_o,
    output logic                             valid_o,
    output logic                             last_element_o,
    output logic                             busy_o,
    output logic [$clog2(DEPTH+1)-1:0]       count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(DEPTH + N);

    typedef enum logic {
        LOAD,
        STREAM
    } state_e;

    state_e                          state_q, state_d;
    logic [CW-1:0]                   count_q, count_d;
    logic [SW-1:0]                   s_q, s_d;
    logic [0:N-1][DATA_WIDTH-1:0]    mem_q [DEPTH];

    logic                            we;
    logic                            stream_d;
    logic [SW-1:0]                   idx;
    logic [0:N-1][DATA_WIDTH-1:0]    data_d;
    logic                            valid_d;
    logic                            last_d;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        s_d          = s_q;
        we           = 1'b0;
        load_ready_o = (state_q == LOAD) && (count_q < CW'(DEPTH));
        unique case (state_q)
            LOAD: begin
                we = load_valid_i && load_ready_o;
                if (we) begin
                    count_d = count_q + CW'(1);
                end
                // A beat accepted with start is stored first and streamed.
                if (start_i && (count_d != '0)) begin
                    state_d = STREAM;
                    s_d     = '0;
                end
            end
            STREAM: begin
                if (s_q == SW'(count_q) + SW'(N - 1) - SW'(1)) begin
                    state_d = LOAD;
                    count_d = '0;
                    s_d     = '0;
                end else begin
                    s_d = s_q + SW'(1);
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // Outputs are computed from next state so they can be registered and
    // still show element 0 on lane 0 in the first cycle after start.
    always_comb begin
        stream_d = (state_d == STREAM);
        valid_d  = stream_d && (s_d < SW'(count_d));
        last_d   = stream_d
                && (s_d == SW'(count_d) + SW'(N - 1) - SW'(1));
        data_d   = '0;
        idx      = '0;
        for (int i = 0; i < N; i++) begin
            idx = s_d - SW'(i);
            if (stream_d && (s_d >= SW'(i)) && (idx < SW'(count_d))) begin
                // The slot being written this edge is not in mem_q yet.
                if (we && (idx == SW'(count_q))) begin
                    data_d[i] = load_data_i[i];
                end else begin
                    for (int k = 0; k < DEPTH; k++) begin
                        if (idx == SW'(k)) begin
                            data_d[i] = mem_q[k][i];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q        <= LOAD;
            count_q        <= '0;
            s_q            <= '0;
            data_o         <= '0;
            valid_o        <= 1'b0;
            last_element_o <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            s_q            <= s_d;
            data_o         <= data_d;
            valid_o        <= valid_d;
            last_element_o <= last_d;
            busy_o         <= stream_d;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < DEPTH; k++) begin
            if (we && (count_q == CW'(k))) begin
                mem_q[k] <= load_data_i;
            end
        end
    end

    assign count_o = count_q;

endmodule

// File: tb/tb_input_skew_queue.sv
// tb_input_skew_queue: directed plus randomized checks of input_skew_queue
// against a queue-based model of the skewed stream.
module tb_input_skew_queue;

    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef logic [0:N-1][DW-1:0] vec_t;

    logic             clk;
    logic             rstn_i;
    logic             load_valid_i;
    logic             load_ready_o;
    vec_t             load_data_i;
    logic             start_i;
    vec_t             data_o;
    logic             valid_o;
    logic             last_element_o;
    logic             busy_o;
    logic [CW-1:0]    count_o;

    int               passed;
    int               total;
    vec_t             ref_q[$];

    input_skew_queue #(
        .N         (N),
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rstn_i        (rstn_i),
        .load_valid_i  (load_valid_i),
        .load_ready_o  (load_ready_o),
        .load_data_i   (load_data_i),
        .start_i       (start_i),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .last_element_o(last_element_o),
        .busy_o        (busy_o),
        .count_o       (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Offer k beats; base<0 gives random data, else lane i of beat j is
    // base+16j+i. Optionally raise start with the last beat.
    task automatic load(input int k, input bit start_last, input int base);
        vec_t v;
        for (int j = 0; j < k; j++) begin
            for (int i = 0; i < N; i++) begin
                if (base < 0) v[i] = $urandom;
                else v[i] = DW'(base + 16 * j + i);
            end
            chk("load_ready", load_ready_o, ref_q.size() < DEPTH);
            load_valid_i = 1'b1;
            load_data_i  = v;
            start_i      = start_last && (j == k - 1);
            if (ref_q.size() < DEPTH) ref_q.push_back(v);
            tick();
            load_valid_i = 1'b0;
            start_i      = 1'b0;
            chk("count_load", count_o, ref_q.size());
        end
    endtask

    task automatic start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Called at cycle T+1. Lane i at stream cycle c carries vector c-i.
    // If mid>=0, start and a load beat are offered at that stream cycle.
    task automatic stream_check(input int mid);
        int   n;
        logic [DW-1:0] e;
        n = ref_q.size();
        for (int c = 0; c <= n + N - 1; c++) begin
            if (c < n + N - 1) begin
                for (int i = 0; i < N; i++) begin
                    if (c - i >= 0 && c - i < n) e = ref_q[c-i][i];
                    else e = '0;
                    chk($sformatf("lane%0d_c%0d", i, c), data_o[i], e);
                end
                chk($sformatf("valid_c%0d", c), valid_o, c < n);
                chk($sformatf("last_c%0d", c), last_element_o,
                    c == n + N - 2);
                chk("busy_stream", busy_o, 1'b1);
                chk("ready_stream", load_ready_o, 1'b0);
                chk("count_stream", count_o, n);
            end else begin
                chk("busy_after", busy_o, 1'b0);
                chk("valid_after", valid_o, 1'b0);
                chk("data_after", data_o, '0);
                chk("ready_after", load_ready_o, 1'b1);
                chk("count_after", count_o, 0);
            end
            start_i      = (c == mid);
            load_valid_i = (c == mid);
            load_data_i  = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        start_i      = 1'b0;
        load_valid_i = 1'b0;
        ref_q.delete();
    endtask

    initial begin
        passed       = 0;
        total        = 0;
        rstn_i       = 1'b1;
        load_valid_i = 1'b0;
        load_data_i  = '0;
        start_i      = 1'b0;
        #2 rstn_i = 1'b0;
        #2;
        chk("rst_data", data_o, '0);
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_last", last_element_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_count", count_o, 0);
        chk("rst_ready", load_ready_o, 1'b1);
        tick();
        tick();
        rstn_i = 1'b1;
        tick();
        chk("post_rst_count", count_o, 0);

        start();
        chk("empty_start_busy", busy_o, 1'b0);
        tick();
        chk("empty_start_busy2", busy_o, 1'b0);
        chk("empty_start_count", count_o, 0);

        load(3, 1'b0, 0);
        start();
        stream_check(-1);

        load(10, 1'b0, -1);
        start();
        stream_check(2);

        load(1, 1'b1, 'hA0);
        stream_check(-1);

        for (int r = 0; r < 4; r++) begin
            int  k;
            bit  sl;
            k  = $urandom_range(1, DEPTH + 1);
            sl = 1'($urandom_range(0, 1));
            load(k, sl, -1);
            if (!sl) start();
            stream_check(int'($urandom_range(0, 3)));
        end

        load(5, 1'b0, -1);
        start();
        tick();
        tick();
        chk("pre_rst_busy", busy_o, 1'b1);
        chk("pre_rst_valid", valid_o, 1'b1);
        #3 rstn_i = 1'b0;
        #1;
        chk("mid_rst_data", data_o, '0);
        chk("mid_rst_valid", valid_o, 1'b0);
        chk("mid_rst_last", last_element_o, 1'b0);
        chk("mid_rst_busy", busy_o, 1'b0);
        chk("mid_rst_count", count_o, 0);
        chk("mid_rst_ready", load_ready_o, 1'b1);
        ref_q.delete();
        #1 rstn_i = 1'b1;
        tick();
        chk("after_rst_count", count_o, 0);
        chk("after_rst_busy", busy_o, 1'b0);
        load(1, 1'b1, -1);
        stream_check(-1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
